// File: rtl/register_dump_pkg.sv
// Shared types and constants for the register dump streamer.
package register_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    HART,
    DATA,
    CSUM
  } dump_state_t;

  localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

  function automatic int unsigned bytes_per_reg(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/register_dump_byte_select.sv
// Picks one byte of the register snapshot by register index and byte index (little-endian).
module register_dump_byte_select
  import register_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned REG_IDX_W  = 6,
  parameter int unsigned BYTE_IDX_W = 2
) (
  input  logic [(NUM_REGS+1)*REG_WIDTH-1:0] snapshot,
  input  logic [REG_IDX_W-1:0]              reg_idx,
  input  logic [BYTE_IDX_W-1:0]             byte_idx,
  output logic [7:0]                        data
);

  localparam int unsigned BPR = bytes_per_reg(REG_WIDTH);

  always_comb begin
    data = '0;
    for (int unsigned r = 0; r <= NUM_REGS; r++) begin
      for (int unsigned b = 0; b < BPR; b++) begin
        if (32'(reg_idx) == r && 32'(byte_idx) == b) begin
          data = snapshot[r*REG_WIDTH + b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/register_dump_streamer.sv
// Snapshots one hart's PC + general registers and streams them as a framed byte sequence.
// Optional trailing checksum byte: define REGISTER_DUMP_CHECKSUM_EN.
module register_dump_streamer
  import register_dump_pkg::*;
#(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned HART_SEL_WIDTH = 1
) (
  input  logic                                      clock,
  input  logic                                      clear_n,
  input  logic [NUM_HARTS*(NUM_REGS+1)*REG_WIDTH-1:0] registers,
  input  logic                                      dump_req,
  input  logic [HART_SEL_WIDTH-1:0]                 hart_sel,
  output logic [7:0]                                out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      req_error
);

  localparam int unsigned BPR        = bytes_per_reg(REG_WIDTH);
  localparam int unsigned SLICE      = (NUM_REGS + 1) * REG_WIDTH;
  localparam int unsigned REG_IDX_W  = (NUM_REGS > 0) ? $clog2(NUM_REGS + 1) : 1;
  localparam int unsigned BYTE_IDX_W = (BPR > 1) ? $clog2(BPR) : 1;

  dump_state_t             state;
  logic [SLICE-1:0]        snapshot;
  logic [SLICE-1:0]        sel_slice;
  logic [7:0]              hart_byte;
  logic [REG_IDX_W-1:0]    reg_idx, nxt_reg;
  logic [BYTE_IDX_W-1:0]   byte_idx, nxt_byte;
  logic [7:0]              sel_byte;
  logic                    req_ok;
  logic                    xfer;
  logic                    last_byte;
`ifdef REGISTER_DUMP_CHECKSUM_EN
  logic [7:0]              csum_acc;
`endif

  assign xfer      = out_valid && out_ready;
  assign req_ok    = 32'(hart_sel) < NUM_HARTS;
  assign last_byte = (32'(reg_idx) == NUM_REGS) && (32'(byte_idx) == BPR - 1);

  always_comb begin
    sel_slice = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (32'(hart_sel) == h) sel_slice = registers[h*SLICE +: SLICE];
    end
  end

  // The mux looks one byte ahead so out_data can be registered on the handshake edge.
  always_comb begin
    nxt_reg  = reg_idx;
    nxt_byte = byte_idx + 1'b1;
    if (state == HART) begin
      nxt_reg  = '0;
      nxt_byte = '0;
    end else if (32'(byte_idx) == BPR - 1) begin
      nxt_reg  = reg_idx + 1'b1;
      nxt_byte = '0;
    end
  end

  register_dump_byte_select #(
    .NUM_REGS   (NUM_REGS),
    .REG_WIDTH  (REG_WIDTH),
    .REG_IDX_W  (REG_IDX_W),
    .BYTE_IDX_W (BYTE_IDX_W)
  ) u_byte_select (
    .snapshot (snapshot),
    .reg_idx  (nxt_reg),
    .byte_idx (nxt_byte),
    .data     (sel_byte)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      snapshot  <= '0;
      hart_byte <= '0;
      reg_idx   <= '0;
      byte_idx  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_error <= 1'b0;
`ifdef REGISTER_DUMP_CHECKSUM_EN
      csum_acc  <= '0;
`endif
    end else begin
      done      <= 1'b0;
      req_error <= 1'b0;
`ifdef REGISTER_DUMP_CHECKSUM_EN
      if (xfer) csum_acc <= csum_acc + out_data;
`endif
      unique case (state)
        IDLE: begin
          if (dump_req) begin
            if (req_ok) begin
              snapshot  <= sel_slice;
              hart_byte <= 8'(hart_sel);
              reg_idx   <= '0;
              byte_idx  <= '0;
              out_data  <= DUMP_HEADER_BYTE;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= HEADER;
`ifdef REGISTER_DUMP_CHECKSUM_EN
              csum_acc  <= '0;
`endif
            end else begin
              req_error <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (xfer) begin
            out_data <= hart_byte;
            state    <= HART;
          end
        end
        HART: begin
          if (xfer) begin
            out_data <= sel_byte;
            state    <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (last_byte) begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
              out_data  <= 8'h00 - (csum_acc + out_data);
              state     <= CSUM;
`else
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
`endif
            end else begin
              reg_idx  <= nxt_reg;
              byte_idx <= nxt_byte;
              out_data <= sel_byte;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_streamer.sv
// Directed bench for register_dump_streamer: default single-hart build plus a 4-hart, 16-bit instance.
module tb_register_dump_streamer;

`ifdef REGISTER_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int LEN0 = 134 + CS;
  localparam int LEN1 = 10 + CS;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              clear_n;
  logic [33*32-1:0]  regs_bus0, snap0;
  logic              dump_req0, out_valid0, out_ready0, busy0, done0, req_error0;
  logic [0:0]        hart_sel0;
  logic [7:0]        out_data0;

  logic [4*4*16-1:0] regs_bus1;
  logic              dump_req1, out_valid1, out_ready1, busy1, done1, req_error1;
  logic [2:0]        hart_sel1;
  logic [7:0]        out_data1;

  logic [7:0] cap0 [300];
  logic [7:0] cap1 [64];
  int errors = 0;
  int checks = 0;

  register_dump_streamer u0 (
    .clock(clock), .clear_n(clear_n), .registers(regs_bus0), .dump_req(dump_req0),
    .hart_sel(hart_sel0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .busy(busy0), .done(done0), .req_error(req_error0)
  );

  register_dump_streamer #(
    .NUM_HARTS(4), .NUM_REGS(3), .REG_WIDTH(16), .HART_SEL_WIDTH(3)
  ) u1 (
    .clock(clock), .clear_n(clear_n), .registers(regs_bus1), .dump_req(dump_req1),
    .hart_sel(hart_sel1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .busy(busy1), .done(done1), .req_error(req_error1)
  );

  typedef struct { int pos; logic [7:0] exp; } byte_vec_t;
  typedef struct { logic [2:0] sel; bit err; logic [7:0] b2; logic [7:0] b3; } hart_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] raw0(input int k);
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'h00;
    return snap0[(k-2)*8 +: 8];
  endfunction

  function automatic logic [7:0] exp0(input int k);
    logic [7:0] s;
    if (CS == 1 && k == LEN0 - 1) begin
      s = 8'h00;
      for (int j = 0; j < k; j++) s = s + raw0(j);
      return 8'h00 - s;
    end
    return raw0(k);
  endfunction

  function automatic logic [7:0] raw1(input int k, input int h);
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'(h);
    return regs_bus1[h*64 + (k-2)*8 +: 8];
  endfunction

  function automatic logic [7:0] exp1(input int k, input int h);
    logic [7:0] s;
    if (CS == 1 && k == LEN1 - 1) begin
      s = 8'h00;
      for (int j = 0; j < k; j++) s = s + raw1(j, h);
      return 8'h00 - s;
    end
    return raw1(k, h);
  endfunction

  task automatic set_pattern0();
    regs_bus0[31:0] = 32'h8000_0010;
    for (int i = 0; i < 32; i++) regs_bus0[(i+1)*32 +: 32] = 32'(32'h1111_1111 * i);
  endtask

  task automatic start0();
    @(negedge clock);
    snap0     = regs_bus0;
    hart_sel0 = 1'b0;
    dump_req0 = 1'b1;
    @(negedge clock);
    dump_req0 = 1'b0;
    check("accept_busy", 32'(busy0), 32'd1);
    check("accept_valid", 32'(out_valid0), 32'd1);
    check("accept_header", 32'(out_data0), 32'hA5);
  endtask

  // Starts at the negedge where the header is first valid; k counts edges since acceptance.
  task automatic collect(input bit toggle, input int disturb_at, input int abort_at,
                         output int n, output int last, output int done_k);
    int k;
    bit stalled;
    logic [7:0] prev;
    n = 0; last = -1; done_k = -1; k = 0; stalled = 1'b0; prev = 8'h00;
    while (done_k < 0 && k < 1000) begin
      out_ready0 = toggle ? (k % 2 == 1) : 1'b1;
      if (k == disturb_at) begin
        dump_req0 = 1'b1;
        regs_bus0 = ~regs_bus0;
      end else begin
        dump_req0 = 1'b0;
      end
      if (stalled) check("stall_hold", {23'd0, out_valid0, out_data0}, {23'd0, 1'b1, prev});
      if (out_valid0 && out_ready0) begin
        cap0[n] = out_data0;
        n++;
        last = k + 1;
        if (n == abort_at) begin
          clear_n = 1'b0;
          #1;
          check("abort_valid", 32'(out_valid0), 32'd0);
          check("abort_busy", 32'(busy0), 32'd0);
          dump_req0 = 1'b0;
          return;
        end
      end
      stalled = out_valid0 && !out_ready0;
      prev    = out_data0;
      @(negedge clock);
      k++;
      if (done0) done_k = k;
    end
    dump_req0 = 1'b0;
  endtask

  task automatic compare_frame0(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n && i < LEN0; i++) if (cap0[i] !== exp0(i)) bad++;
    check({name, "_bytes_wrong"}, 32'(bad), 32'd0);
    check({name, "_length"}, 32'(n), 32'(LEN0));
  endtask

  byte_vec_t first_bytes [10];
  hart_vec_t hart_tab [6];
  int n, last, done_k;

  initial begin
    first_bytes = '{'{0, 8'hA5}, '{1, 8'h00}, '{2, 8'h10}, '{3, 8'h00}, '{4, 8'h00},
                    '{5, 8'h80}, '{6, 8'h00}, '{7, 8'h00}, '{8, 8'h00}, '{9, 8'h00}};
    hart_tab = '{'{3'd2, 1'b0, 8'hAB, 8'h20}, '{3'd5, 1'b1, 8'h00, 8'h00},
                 '{3'd3, 1'b0, 8'hAB, 8'h30}, '{3'd4, 1'b1, 8'h00, 8'h00},
                 '{3'd0, 1'b0, 8'hAB, 8'h00}, '{3'd7, 1'b1, 8'h00, 8'h00}};

    clear_n = 1'b0;
    dump_req0 = 1'b0; hart_sel0 = '0; out_ready0 = 1'b0; regs_bus0 = '0; snap0 = '0;
    dump_req1 = 1'b0; hart_sel1 = '0; out_ready1 = 1'b0;
    for (int h = 0; h < 4; h++)
      for (int i = 0; i < 4; i++)
        regs_bus1[(h*4+i)*16 +: 16] = 16'(16'h1000*h + 16'h0100*i + 16'h00AB);
    set_pattern0();
    @(negedge clock);
    @(negedge clock);
    check("rst_data", 32'(out_data0), 32'd0);
    check("rst_valid", 32'(out_valid0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_req_error", 32'(req_error0), 32'd0);
    check("rst_valid_u1", 32'(out_valid1), 32'd0);
    clear_n = 1'b1;

    // Full-rate frame from hart 0.
    start0();
    collect(1'b0, -1, -1, n, last, done_k);
    foreach (first_bytes[i])
      check($sformatf("byte%0d", first_bytes[i].pos), 32'(cap0[first_bytes[i].pos]), 32'(first_bytes[i].exp));
    compare_frame0("fullrate", n);
    check("fullrate_last_edge", 32'(last), 32'(LEN0));
    check("fullrate_done_cycle", 32'(done_k + 1), 32'(LEN0 + 1));
    @(negedge clock);
    check("done_one_cycle", {29'd0, done0, busy0, out_valid0}, 32'd0);

    // Backpressure: out_ready toggles every cycle.
    start0();
    collect(1'b1, -1, -1, n, last, done_k);
    compare_frame0("backpressure", n);
    check("backpressure_last_edge", 32'(last), 32'(2*LEN0));
    check("backpressure_done", 32'(done_k), 32'(last));

    // Request issued in the done cycle is accepted; mid-frame request and register change ignored.
    snap0 = regs_bus0;
    dump_req0 = 1'b1;
    @(negedge clock);
    dump_req0 = 1'b0;
    check("done_cycle_accept", {30'd0, busy0, out_valid0}, 32'd3);
    check("done_cycle_header", 32'(out_data0), 32'hA5);
    collect(1'b0, 20, -1, n, last, done_k);
    compare_frame0("snapshot", n);
    @(negedge clock);
    check("midframe_req_ignored", {30'd0, busy0, out_valid0}, 32'd0);

    // All-zero registers.
    regs_bus0 = '0;
    start0();
    collect(1'b0, -1, -1, n, last, done_k);
    compare_frame0("zeros", n);
`ifdef REGISTER_DUMP_CHECKSUM_EN
    check("zero_checksum", 32'(cap0[LEN0-1]), 32'h5B);
`endif

    // Reset mid-frame, then restart.
    set_pattern0();
    start0();
    collect(1'b0, -1, 50, n, last, done_k);
    @(negedge clock);
    check("abort_no_done", 32'(done0), 32'd0);
    clear_n = 1'b1;
    start0();
    collect(1'b0, -1, -1, n, last, done_k);
    check("restart_header", 32'(cap0[0]), 32'hA5);
    compare_frame0("restart", n);

    // Multi-hart instance: valid and invalid hart selections.
    foreach (hart_tab[v]) begin
      @(negedge clock);
      hart_sel1 = hart_tab[v].sel;
      dump_req1 = 1'b1;
      out_ready1 = 1'b1;
      @(negedge clock);
      dump_req1 = 1'b0;
      check($sformatf("u1_req_error_sel%0d", hart_tab[v].sel), 32'(req_error1), 32'(hart_tab[v].err));
      check($sformatf("u1_valid_sel%0d", hart_tab[v].sel), 32'(out_valid1), 32'(!hart_tab[v].err));
      if (hart_tab[v].err) begin
        @(negedge clock);
        check("u1_req_error_pulse", {30'd0, req_error1, out_valid1}, 32'd0);
      end else begin
        int m, bad;
        m = 0;
        for (int c = 0; c < 40 && !done1; c++) begin
          if (out_valid1 && out_ready1) begin
            cap1[m] = out_data1;
            m++;
          end
          @(negedge clock);
        end
        check("u1_done", 32'(done1), 32'd1);
        check("u1_length", 32'(m), 32'(LEN1));
        check("u1_hart_byte", 32'(cap1[1]), 32'(hart_tab[v].sel));
        check("u1_pc_lo", 32'(cap1[2]), 32'(hart_tab[v].b2));
        check("u1_pc_hi", 32'(cap1[3]), 32'(hart_tab[v].b3));
        bad = 0;
        for (int i = 0; i < m && i < LEN1; i++) if (cap1[i] !== exp1(i, int'(hart_tab[v].sel))) bad++;
        check("u1_bytes_wrong", 32'(bad), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_dump_streamer.md
# register_dump_streamer

Multi-hart debug block that snapshots one hart's architectural register file (PC plus general registers) on request. It then streams the snapshot as a framed byte sequence over a valid/ready byte interface, and sits between the CPU register outputs and the UART transmitter. It generalises the fixed single-hart, 32×32-bit register export to configurable hart count, register count and register width, and adds a framed on-demand dump with an optional checksum.

## Interface
Parameters:
- NUM_HARTS, default 1: number of register sets on the input bus.
- NUM_REGS, default 32: general registers per hart, excluding PC.
- REG_WIDTH, default 32: bits per register; must be a multiple of 8.
- HART_SEL_WIDTH, default 1: width of hart_sel; must be at least 1 and hold NUM_HARTS-1.

Ports:
- clock  in  1  sole clock.
- clear_n  in  1  asynchronous, active-low reset.
- registers  in  NUM_HARTS*(NUM_REGS+1)*REG_WIDTH  per hart, PC in the lowest REG_WIDTH bits, then general0..general(NUM_REGS-1) ascending; hart 0 in the lowest slice.
- dump_req  in  1  single-cycle request; sampled in IDLE only.
- hart_sel  in  HART_SEL_WIDTH  hart to dump; sampled with dump_req.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame completion.
- req_error  out  1  one-cycle pulse when a request names a hart that does not exist.

## Operation
- Frame order: 0xA5 header, hart id (zero-extended to 8 bits), PC bytes, general0..general(NUM_REGS-1) bytes. Each register is sent little-endian, REG_WIDTH/8 bytes. The checksum byte follows if enabled.
- Snapshot: on an accepted request, the selected hart's full register slice is copied into an internal snapshot register. The frame is built only from the snapshot, so later register changes do not appear in it.
- States:
  - IDLE: on dump_req with hart_sel < NUM_HARTS, capture the snapshot and go to HEADER. On dump_req with hart_sel >= NUM_HARTS, pulse req_error and stay in IDLE.
  - HEADER → HART → DATA on each handshake.
  - DATA walks register index 0..NUM_REGS and byte index 0..REG_WIDTH/8-1. On the last byte it goes to CSUM (macro defined) or IDLE.
  - CSUM → IDLE on handshake.
- Handshake: a transfer occurs when out_valid and out_ready are both high at a clock edge.
  - out_data stays stable while out_valid is high and out_ready is low.
  - out_valid never drops without a transfer.
- dump_req while busy is ignored; no queueing.
- Register and byte counters reset to 0 on every accepted request.

## Timing
- Reset values: out_data 0, out_valid 0, busy 0, done 0, req_error 0, state IDLE, counters 0.
- Asserting clear_n low mid-frame aborts the frame immediately. No partial completion and no done pulse.
- Request accepted at edge N: busy and out_valid are high from cycle N+1, carrying the header byte.
- With out_ready held high, one byte transfers per cycle.
  - Frame length: 2 + (NUM_REGS+1)*REG_WIDTH/8 bytes, plus 1 with checksum.
  - Defaults: 134 bytes, or 135 with checksum.
- After the final transfer edge: busy and out_valid are low and done is high for exactly one cycle. A dump_req in that cycle is accepted.
- req_error pulses in the cycle after the rejected request.

## Configuration
- REGISTER_DUMP_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) is kept over all frame bytes, header included.
  - The final byte is the two's complement of that sum, so the whole frame sums to 0x00.
- Not defined: no checksum logic exists and the frame ends on the last register byte.

## Structure
- Shared package register_dump_pkg holds:
  - the state enum (IDLE, HEADER, HART, DATA, CSUM);
  - the constant DUMP_HEADER_BYTE = 8'hA5;
  - a function bytes_per_reg(width).
- One sub-module, register_dump_byte_select: combinational mux from the snapshot plus register and byte indices to out_data.

## Test plan
- Defaults, hart 0 with PC=0x8000_0010 and general[i]=0x1111_1111*i (32-bit truncation), out_ready=1, checksum off:
  - bytes 0..9 = A5 00 10 00 00 80 00 00 00 00;
  - 134 bytes total;
  - done on cycle 135 after request.
- Backpressure: toggle out_ready every cycle → out_data holds across stalls; identical byte sequence; frame takes 268 cycles.
- NUM_HARTS=4, hart_sel=2 → hart byte 0x02 and hart 2's PC. Then hart_sel=5 with HART_SEL_WIDTH=3 → req_error pulse, out_valid stays 0.
- Change registers and issue a second dump_req mid-frame → streamed bytes match the original snapshot; second request ignored.
- Checksum on, all registers 0 → final byte 0x5B (0xA5 + 0x00 + 0x5B = 0x100 ≡ 0x00 mod 256).
- clear_n low at byte 50 → out_valid and busy 0 asynchronously. The next request restarts with the header 0xA5.
